// File: rtl/uart_digest_loader_if.sv
// Digest loader bus: serial input from the host and the digest presented
// to the generator/comparator. The loader owns the master side.
interface uart_digest_loader_if;
  logic         rx;            // UART serial line, idle high
  logic [0:127] target;        // last accepted digest, first byte in [0:7]
  logic         target_valid;  // one-cycle pulse when target updates
  logic         busy;          // partial frame held or byte in flight
  logic         frame_err;     // one-cycle pulse on stop/timeout/checksum error
  logic         rx_led;        // bit engine outside IDLE
  logic [2:0]   bit_state;     // debug view of the bit engine state

  modport master (
    input  rx,
    output target, target_valid, busy, frame_err, rx_led, bit_state
  );

  modport slave (
    output rx,
    input  target, target_valid, busy, frame_err, rx_led, bit_state
  );
endinterface

// File: rtl/uart_digest_loader.sv
// uart_digest_loader: 8N1 UART receiver that assembles 16 host bytes into a
// 128-bit target digest. Optional macro DIGEST_CHECKSUM_EN appends a 17th
// byte that must equal the XOR of the 16 digest bytes.
// Handshake: target_valid is a one-cycle strobe with no ready; target is
// stable from that strobe until the next strobe or reset.
module uart_digest_loader #(
  parameter int CLKS_PER_BIT = 104,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_digest_loader_if.master  dl
);

  localparam int HALF      = CLKS_PER_BIT / 2;
  localparam int TICK_W    = $clog2(CLKS_PER_BIT);
  localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int IDLE_W    = $clog2(TO_CYCLES + 1);
`ifdef DIGEST_CHECKSUM_EN
  localparam int         SHADOW_BYTES = 16;
  localparam logic [4:0] LAST_K       = 5'd16;
`else
  localparam int         SHADOW_BYTES = 15;
  localparam logic [4:0] LAST_K       = 5'd15;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
  } state_t;

  logic [1:0]              sync_q;
  logic                    rxs;
  state_t                  state_q, state_d;
  logic [TICK_W-1:0]       tick_q, tick_d;
  logic [2:0]              bit_q, bit_d;
  logic [7:0]              shift_q, shift_d;
  logic                    byte_done, stop_err, start_seen;
  logic                    tick_last, tick_half;
  logic [4:0]              k_q, k_d;
  logic [0:8*SHADOW_BYTES-1] shadow_q, shadow_d;
  logic [0:127]            target_q, target_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;
  logic [IDLE_W-1:0]       idle_q, idle_d;
`ifdef DIGEST_CHECKSUM_EN
  logic [7:0]              xor_q, xor_d;
`endif

  assign rxs       = sync_q[1];
  assign tick_last = (tick_q == TICK_W'(CLKS_PER_BIT - 1));
  assign tick_half = (tick_q == TICK_W'(HALF - 1));

  // Two-flop synchronizer; resets to idle-high so no false start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], dl.rx};
  end

  // Bit engine state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Bit engine: mid-bit sampling, LSB first, stuck-low guard after bad stop.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_done  = 1'b0;
    stop_err   = 1'b0;
    start_seen = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d    = S_START;
          tick_d     = '0;
          start_seen = 1'b1;
        end
      end
      S_START: begin
        if (tick_half) begin
          tick_d  = '0;
          bit_d   = 3'd0;
          state_d = rxs ? S_IDLE : S_DATA;   // high again: glitch, no error
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_DATA: begin
        if (tick_last) begin
          tick_d  = '0;
          shift_d = {rxs, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_STOP: begin
        if (tick_last) begin
          tick_d = '0;
          if (rxs) begin
            byte_done = 1'b1;
            state_d   = S_IDLE;
          end else begin
            stop_err = 1'b1;
            state_d  = S_WAIT_HIGH;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_WAIT_HIGH: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame assembler state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q      <= '0;
      shadow_q <= '0;
      target_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      idle_q   <= '0;
`ifdef DIGEST_CHECKSUM_EN
      xor_q    <= '0;
`endif
    end else begin
      k_q      <= k_d;
      shadow_q <= shadow_d;
      target_q <= target_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      idle_q   <= idle_d;
`ifdef DIGEST_CHECKSUM_EN
      xor_q    <= xor_d;
`endif
    end
  end

  // Assembler: collect bytes, publish whole digest only, drop stale frames.
  always_comb begin
    k_d      = k_q;
    shadow_d = shadow_q;
    target_d = target_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    idle_d   = idle_q;
`ifdef DIGEST_CHECKSUM_EN
    xor_d    = xor_q;
`endif
    if (start_seen || k_q == 5'd0) begin
      idle_d = '0;
    end else if (state_q == S_IDLE) begin
      if (idle_q == IDLE_W'(TO_CYCLES - 1)) begin
        err_d  = 1'b1;
        k_d    = 5'd0;
        idle_d = '0;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end
    if (stop_err) begin
      err_d = 1'b1;
      k_d   = 5'd0;
    end
    if (byte_done) begin
      if (k_q == LAST_K) begin
        k_d = 5'd0;
`ifdef DIGEST_CHECKSUM_EN
        if (shift_q == xor_q) begin
          target_d = shadow_q;
          valid_d  = 1'b1;
        end else begin
          err_d = 1'b1;
        end
`else
        target_d = {shadow_q, shift_q};
        valid_d  = 1'b1;
`endif
      end else begin
        shadow_d[{k_q[3:0], 3'b000} +: 8] = shift_q;
        k_d = k_q + 5'd1;
`ifdef DIGEST_CHECKSUM_EN
        xor_d = xor_q ^ shift_q;
`endif
      end
    end
`ifdef DIGEST_CHECKSUM_EN
    if (k_d == 5'd0) xor_d = 8'h00;
`endif
  end

  assign dl.target       = target_q;
  assign dl.target_valid = valid_q;
  assign dl.frame_err    = err_q;
  assign dl.busy         = (k_q != 5'd0) || (state_q != S_IDLE);
  assign dl.rx_led       = (state_q != S_IDLE);
  assign dl.bit_state    = state_q;

endmodule
